// File: rtl/riscv_pkg.sv
// Shared fetch-path definitions: widths, reset PC, opcode constants and the
// {instr, pc} packet carried from instruction memory to decode.
package riscv_pkg;

    localparam int XLEN = 32;
    localparam int ILEN = 32;

    localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;

    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;

    typedef struct packed {
        logic [ILEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_pkt_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetch packets with a flush that empties it at the
// clock edge. DEPTH must be a power of two so the pointers wrap naturally.
module fetch_fifo
    import riscv_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  fetch_pkt_t    wdata,
    input  logic          pop,
    input  logic          flush,
    output fetch_pkt_t    rdata,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    fetch_pkt_t    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // NOTE: every variable assigned here gets a default first, so no latch is inferred.
    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; count_q guards every read of it.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wdata;
    end

    assign rdata = mem_q[rd_ptr_q];
    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch front end: issues in-order word fetches under a credit limit, buffers
// responses with their PC and hands {instr, pc} to decode; redirect flushes.
module instr_fetch_unit
    import riscv_pkg::*;
#(
    parameter int               XLEN       = riscv_pkg::XLEN,
    parameter logic [XLEN-1:0]  RESET_PC   = riscv_pkg::RESET_PC,
    parameter int               FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [31:0]     imem_resp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [31:0]     if_instr,
    output logic [XLEN-1:0] if_pc
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [CW-1:0]   outstanding_q, outstanding_d;
    logic [CW-1:0]   drop_q, drop_d;

    logic            req_fire;
    logic [CW:0]     committed;
    logic [XLEN-1:0] resp_pc;

    fetch_pkt_t      fifo_wdata;
    fetch_pkt_t      fifo_rdata;
    logic            fifo_push;
    logic            fifo_pop;
    logic            fifo_full;
    logic            fifo_empty;
    logic [CW-1:0]   fifo_count;

    // A pop this cycle frees its slot for a request this cycle, which is what
    // sustains one instruction per cycle with only two credits.
    assign committed = {1'b0, outstanding_q} + {1'b0, fifo_count} - {{CW{1'b0}}, fifo_pop};

    assign imem_req_valid = !rst && !redirect_valid && (committed < (CW+1)'(FIFO_DEPTH));
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // Once drop_q is zero every outstanding request is post-redirect and
    // sequential, so the oldest one sits outstanding_q words behind fetch_pc_q.
    assign resp_pc    = fetch_pc_q - (XLEN'(outstanding_q) << 2);
    assign fifo_wdata = '{instr: imem_resp_data, pc: resp_pc};
    assign fifo_push  = imem_resp_valid && (drop_q == '0) && !redirect_valid;

    assign if_valid = !rst && !fifo_empty && !redirect_valid;
    assign fifo_pop = if_valid && if_ready;
    assign if_instr = fifo_empty ? '0 : fifo_rdata.instr;
    assign if_pc    = fifo_empty ? '0 : fifo_rdata.pc;

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .wdata (fifo_wdata),
        .pop   (fifo_pop),
        .flush (redirect_valid),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        outstanding_d = outstanding_q;
        drop_d        = drop_q;

        if (redirect_valid) begin
            fetch_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
        end else if (req_fire) begin
            fetch_pc_d = fetch_pc_q + XLEN'(4);
        end

        unique case ({req_fire, imem_resp_valid})
            2'b10:   outstanding_d = outstanding_q + CW'(1);
            2'b01:   outstanding_d = outstanding_q - CW'(1);
            default: outstanding_d = outstanding_q;
        endcase

        // Everything still in flight at a redirect is stale, except a response
        // landing this very cycle, which is discarded on the spot.
        if (redirect_valid) begin
            drop_d = outstanding_q - CW'(imem_resp_valid);
        end else if (imem_resp_valid && (drop_q != '0)) begin
            drop_d = drop_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            outstanding_q <= '0;
            drop_q        <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
        end
    end

    a_resp_needs_request : assert property (@(posedge clk) disable iff (rst)
        imem_resp_valid |-> (outstanding_q != '0));

    a_no_push_when_full : assert property (@(posedge clk) disable iff (rst)
        (fifo_push && fifo_full) |-> fifo_pop);

    a_drop_bounded : assert property (@(posedge clk) disable iff (rst)
        drop_q <= outstanding_q);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: an in-order memory model with random latency and
// a program-order reference of request and delivery addresses.
module tb_instr_fetch_unit;
    import riscv_pkg::*;

    localparam int          DEPTH  = 2;
    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] KEY    = 32'hA5A5_0000;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;

    instr_fetch_unit #(
        .XLEN       (32),
        .RESET_PC   (RST_PC),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .if_valid        (if_valid),
        .if_ready        (if_ready),
        .if_instr        (if_instr),
        .if_pc           (if_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference state: where the next request and the next delivery must be.
    logic [31:0] exp_req_pc;
    logic [31:0] exp_pop_pc;
    logic [31:0] mq_addr[$];
    int          mq_due[$];
    int          last_due;
    int          lat_min = 1;
    int          lat_max = 1;
    int          cyc = 0;
    int          n_req = 0;
    int          n_pop = 0;
    int          first_acc;
    int          first_ifv;
    logic [31:0] acc_log[$];
    logic [31:0] pop_log[$];
    bit          stall_prev;
    logic [31:0] stall_instr;
    logic [31:0] stall_pc;

    task automatic clear_logs();
        acc_log.delete();
        pop_log.delete();
    endtask

    task automatic cycle(input bit redir, input logic [31:0] rpc, input bit ifr, input bit mrdy);
        redirect_valid = redir;
        redirect_pc    = rpc;
        if_ready       = ifr;
        imem_req_ready = mrdy;
        if (mq_addr.size() != 0 && mq_due[0] <= cyc) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = mq_addr[0] ^ KEY;
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = $urandom;
        end
        @(negedge clk);

        if (stall_prev) begin
            check("stall_instr", if_instr, stall_instr);
            check("stall_pc", if_pc, stall_pc);
            if (!redir) check("stall_valid", if_valid, 1);
        end
        if (redir) begin
            check("redir_req_blocked", imem_req_valid, 0);
            check("redir_if_blocked", if_valid, 0);
        end
        if (imem_resp_valid) begin
            void'(mq_addr.pop_front());
            void'(mq_due.pop_front());
        end
        if (imem_req_valid && imem_req_ready) begin
            int d;
            check("req_addr", imem_req_addr, exp_req_pc);
            d = cyc + $urandom_range(lat_max, lat_min);
            if (d <= last_due) d = last_due + 1;
            last_due = d;
            mq_addr.push_back(imem_req_addr);
            mq_due.push_back(d);
            acc_log.push_back(imem_req_addr);
            exp_req_pc = exp_req_pc + 32'd4;
            if (first_acc < 0) first_acc = cyc;
            n_req++;
        end
        if (if_valid && if_ready) begin
            check("if_pc", if_pc, exp_pop_pc);
            check("if_instr", if_instr, exp_pop_pc ^ KEY);
            pop_log.push_back(if_pc);
            exp_pop_pc = exp_pop_pc + 32'd4;
            if (first_ifv < 0) first_ifv = cyc;
            n_pop++;
        end
        stall_prev  = if_valid && !if_ready;
        stall_instr = if_instr;
        stall_pc    = if_pc;
        if (redir) begin
            exp_req_pc = {rpc[31:2], 2'b00};
            exp_pop_pc = {rpc[31:2], 2'b00};
            clear_logs();
        end
        check("credit_bound", mq_addr.size() <= DEPTH, 1);

        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst             = 1'b1;
        redirect_valid  = 1'b0;
        redirect_pc     = '0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        if_ready        = 1'b1;
        imem_req_ready  = 1'b1;
        @(negedge clk);
        check("rst_req_valid", imem_req_valid, 0);
        @(posedge clk);
        #1;
        check("rst_if_valid", if_valid, 0);
        check("rst_if_instr", if_instr, 0);
        check("rst_if_pc", if_pc, 0);
        check("rst_req_addr", imem_req_addr, RST_PC);
        check("rst_req_valid_hold", imem_req_valid, 0);
        cyc++;
        mq_addr.delete();
        mq_due.delete();
        last_due   = cyc;
        exp_req_pc = RST_PC;
        exp_pop_pc = RST_PC;
        first_acc  = -1;
        first_ifv  = -1;
        stall_prev = 1'b0;
        clear_logs();
        rst = 1'b0;
    endtask

    initial begin
        int c0;
        int n0;
        int r0;
        bit found;

        // Sequential fetch, 1-cycle memory: latency and throughput.
        do_reset();
        lat_min = 1; lat_max = 1;
        c0 = cyc;
        repeat (8) cycle(1'b0, '0, 1'b1, 1'b1);
        check("t1_first_accept", first_acc, c0);
        check("t1_latency", first_ifv - first_acc, 2);
        if (pop_log.size() >= 3) begin
            check("t1_pc0", pop_log[0], 32'h0);
            check("t1_pc1", pop_log[1], 32'h4);
            check("t1_pc2", pop_log[2], 32'h8);
        end else check("t1_pop_count", pop_log.size(), 3);
        n0 = n_pop;
        repeat (10) cycle(1'b0, '0, 1'b1, 1'b1);
        check("t1_throughput", n_pop - n0, 10);

        // Decode stalled: credit limit caps requests, head holds stable.
        do_reset();
        r0 = n_req;
        repeat (10) cycle(1'b0, '0, 1'b0, 1'b1);
        check("t2_req_count", n_req - r0, 2);
        check("t2_req_blocked", imem_req_valid, 0);
        n0 = n_pop;
        repeat (6) cycle(1'b0, '0, 1'b1, 1'b1);
        check("t2_resume_pops", n_pop - n0, 6);
        if (pop_log.size() >= 2) begin
            check("t2_pc0", pop_log[0], 32'h0);
            check("t2_pc1", pop_log[1], 32'h4);
        end else check("t2_pop_count", pop_log.size(), 2);

        // Redirect with two slow responses in flight.
        do_reset();
        lat_min = 3; lat_max = 3;
        for (int i = 0; i < 20 && mq_addr.size() != 2; i++) cycle(1'b0, '0, 1'b1, 1'b1);
        check("t3_two_outstanding", mq_addr.size(), 2);
        cycle(1'b1, 32'h100, 1'b1, 1'b1);
        repeat (15) cycle(1'b0, '0, 1'b1, 1'b1);
        if (pop_log.size() >= 1) check("t3_first_pc", pop_log[0], 32'h100);
        else check("t3_pop_count", pop_log.size(), 1);

        // Redirect to an unaligned target in the same cycle as a response.
        lat_min = 2; lat_max = 2;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (mq_addr.size() != 0 && mq_due[0] <= cyc) found = 1'b1;
            else cycle(1'b0, '0, 1'b1, 1'b1);
        end
        check("t4_resp_aligned", found, 1);
        cycle(1'b1, 32'h203, 1'b1, 1'b1);
        repeat (10) cycle(1'b0, '0, 1'b1, 1'b1);
        if (acc_log.size() >= 1 && pop_log.size() >= 1) begin
            check("t4_req_addr", acc_log[0], 32'h200);
            check("t4_first_pc", pop_log[0], 32'h200);
        end else check("t4_log_count", acc_log.size() + pop_log.size(), 2);

        // Fetch across the top of the address space.
        lat_min = 1; lat_max = 1;
        cycle(1'b1, 32'hFFFF_FFF8, 1'b1, 1'b1);
        repeat (10) cycle(1'b0, '0, 1'b1, 1'b1);
        if (acc_log.size() >= 3 && pop_log.size() >= 3) begin
            check("t5_req0", acc_log[0], 32'hFFFF_FFF8);
            check("t5_req1", acc_log[1], 32'hFFFF_FFFC);
            check("t5_req2", acc_log[2], 32'h0000_0000);
            check("t5_pc0", pop_log[0], 32'hFFFF_FFF8);
            check("t5_pc1", pop_log[1], 32'hFFFF_FFFC);
            check("t5_pc2", pop_log[2], 32'h0000_0000);
        end else check("t5_log_count", acc_log.size() + pop_log.size(), 6);

        // Reset in the middle of traffic.
        lat_min = 2; lat_max = 2;
        cycle(1'b1, 32'h0000_4000, 1'b1, 1'b1);
        repeat (3) cycle(1'b0, '0, 1'b0, 1'b1);
        check("t6_in_flight", mq_addr.size() != 0, 1);
        do_reset();
        repeat (8) cycle(1'b0, '0, 1'b1, 1'b1);
        if (pop_log.size() >= 2) begin
            check("t6_pc0", pop_log[0], RST_PC);
            check("t6_pc1", pop_log[1], RST_PC + 32'd4);
        end else check("t6_pop_count", pop_log.size(), 2);

        // Random traffic: latency, back-pressure and redirects all mixed.
        n0 = n_pop;
        for (int blk = 0; blk < 6; blk++) begin
            lat_min = 1;
            lat_max = $urandom_range(4, 1);
            for (int i = 0; i < 100; i++) begin
                bit          rd;
                logic [31:0] tgt;
                rd  = ($urandom_range(99) < 4);
                tgt = $urandom;
                cycle(rd, tgt, $urandom_range(3) != 0, $urandom_range(3) != 0);
            end
        end
        check("rand_progress", (n_pop - n0) > 50, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
